// File: rtl/imm_ext_pkg.sv
// Shared types and the pure extension function for the immediate extender.
// Widths are passed as arguments; results are EXT_MAX_W wide and callers truncate.
package imm_ext_pkg;

    localparam int TAG_W     = 4;
    localparam int EXT_MAX_W = 64;

    typedef enum logic [1:0] {
        IMM_ZERO   = 2'd0,
        IMM_SIGN   = 2'd1,
        IMM_UPPER  = 2'd2,
        IMM_BRANCH = 2'd3
    } imm_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } fuse_state_e;

    // imm must arrive zero-padded above imm_w; data_w must not exceed EXT_MAX_W.
    function automatic logic [EXT_MAX_W-1:0] imm_extend(
        input logic [EXT_MAX_W-1:0] imm,
        input imm_mode_e            mode,
        input int                   imm_w,
        input int                   data_w
    );
        logic [EXT_MAX_W-1:0] sext;
        logic [EXT_MAX_W-1:0] res;
        int                   sh;
        sh   = EXT_MAX_W - imm_w;
        sext = $signed(imm << sh) >>> sh;
        case (mode)
            IMM_ZERO:   res = imm;
            IMM_SIGN:   res = sext;
            IMM_UPPER:  res = imm << (data_w - imm_w);
            IMM_BRANCH: res = sext << 2;
            default:    res = imm;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/imm_skid_stage.sv
// Generic main-plus-skid valid/ready register; in_ready is registered so the
// upstream never sees a combinational path from out_ready.
module imm_skid_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_v_q, skid_v_q, rdy_q;
    logic [W-1:0] main_q, skid_q;
    logic         main_v_d, skid_v_d;
    logic [W-1:0] main_d, skid_d;
    logic         acc, drain;

    always_comb begin
        acc      = in_valid && rdy_q;
        drain    = main_v_q && out_ready;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        main_d   = main_q;
        skid_d   = skid_q;
        // rdy_q tracks !skid_v_q, so an accept never coincides with a full skid.
        if (skid_v_q) begin
            if (drain) begin
                main_d   = skid_q;
                skid_v_d = 1'b0;
            end
        end else if (acc) begin
            if (!main_v_q || drain) begin
                main_d   = in_data;
                main_v_d = 1'b1;
            end else begin
                skid_d   = in_data;
                skid_v_d = 1'b1;
            end
        end else if (drain) begin
            main_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            rdy_q    <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            rdy_q    <= !skid_v_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = main_v_q;
    assign out_data  = main_q;

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender with registered skid output stage.
// Optional LUI/ORI fusion enabled by defining IMM_EXT_FUSE_EN.
//   state   | meaning
//   ST_IDLE | no pending upper half; ops pass straight to the output stage
//   ST_HOLD | fused UPPER latched, waiting for a ZERO op to complete it
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [1:0]        in_mode,
    input  logic              in_fuse,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_fused
);

    localparam int PAY_W = DATA_W + TAG_W + 1;

    imm_mode_e         mode;
    logic [DATA_W-1:0] ext_data;
    logic              stg_in_valid, stg_in_ready;
    logic [PAY_W-1:0]  stg_in_pay, stg_out_pay;

    assign mode     = imm_mode_e'(in_mode);
    assign ext_data = DATA_W'(imm_extend(EXT_MAX_W'(in_imm), mode, IMM_W, DATA_W));

`ifdef IMM_EXT_FUSE_EN
    fuse_state_e       state_q, state_d;
    logic [DATA_W-1:0] pend_data_q;
    logic [TAG_W-1:0]  pend_tag_q;
    logic              fuse_start, take, hold_block;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pend_data_q <= '0;
            pend_tag_q  <= '0;
        end else begin
            state_q <= state_d;
            if (fuse_start) begin
                pend_data_q <= ext_data;
                pend_tag_q  <= in_tag;
            end
        end
    end

    always_comb begin
        take       = in_valid && in_ready;
        state_d    = state_q;
        fuse_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (take && mode == IMM_UPPER && in_fuse) begin
                    state_d    = ST_HOLD;
                    fuse_start = 1'b1;
                end
            end
            ST_HOLD: begin
                // A non-ZERO op flushes the pending half unfused once the stage has room.
                if (take || (in_valid && mode != IMM_ZERO && stg_in_ready))
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        hold_block   = (state_q == ST_HOLD) && in_valid && (mode != IMM_ZERO);
        in_ready     = stg_in_ready && !hold_block;
        stg_in_valid = 1'b0;
        stg_in_pay   = {ext_data, in_tag, 1'b0};
        case (state_q)
            ST_IDLE: stg_in_valid = in_valid && !(mode == IMM_UPPER && in_fuse);
            ST_HOLD: begin
                if (in_valid && mode == IMM_ZERO) begin
                    stg_in_valid = 1'b1;
                    stg_in_pay   = {pend_data_q | DATA_W'(in_imm), in_tag, 1'b1};
                end else if (in_valid) begin
                    stg_in_valid = 1'b1;
                    stg_in_pay   = {pend_data_q, pend_tag_q, 1'b0};
                end
            end
            default: stg_in_valid = 1'b0;
        endcase
    end
`else
    logic unused_fuse;
    assign unused_fuse  = in_fuse;
    assign in_ready     = stg_in_ready;
    assign stg_in_valid = in_valid;
    assign stg_in_pay   = {ext_data, in_tag, 1'b0};
`endif

    imm_skid_stage #(.W(PAY_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (stg_in_valid),
        .in_ready  (stg_in_ready),
        .in_data   (stg_in_pay),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (stg_out_pay)
    );

    assign {out_data, out_tag, out_fused} = stg_out_pay;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: queue model plus literal expectations.
// Expectations follow IMM_EXT_FUSE_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid, in_ready, in_fuse;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic [3:0]  in_tag, out_tag;
    logic        out_valid, out_ready, out_fused;
    logic [31:0] out_data;

    imm_extend_pipe #(.IMM_W(16), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
        .in_mode(in_mode), .in_fuse(in_fuse), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_fused(out_fused)
    );

    always #5 clk = ~clk;

`ifdef IMM_EXT_FUSE_EN
    localparam bit FUSE = 1'b1;
`else
    localparam bit FUSE = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  t;
        logic        f;
    } res_t;

    res_t        exp_q[$];
    res_t        log_q[$];
    res_t        mon_e;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_acc = 0;
    int          w;
    bit          m_pend = 1'b0;
    logic [31:0] m_pend_d;
    logic [3:0]  m_pend_t;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_d;
    logic [3:0]  prev_t;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] model_ext(logic [15:0] imm, logic [1:0] mode);
        logic signed [31:0] s;
        s = $signed(imm);
        case (mode)
            2'd0:    return {16'h0000, imm};
            2'd1:    return s;
            2'd2:    return {imm, 16'h0000};
            default: return 32'(s * 4);
        endcase
    endfunction

    // Single compare/model process: check what leaves, then record what enters.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_pend     = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_d);
                chk("stall_tag", out_tag, prev_t);
            end
            if (out_valid && out_ready) begin
                log_q.push_back(res_t'({out_data, out_tag, out_fused}));
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_output: got data 0x%0h tag %0d, none required", out_data, out_tag);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({out_data, out_tag, out_fused} !== {mon_e.d, mon_e.t, mon_e.f}) begin
                        n_errors++;
                        $display("FAIL sb_result: got 0x%0h/%0d/%0b expected 0x%0h/%0d/%0b",
                                 out_data, out_tag, out_fused, mon_e.d, mon_e.t, mon_e.f);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            prev_t     = out_tag;
            if (in_valid) begin
                if (FUSE && m_pend && in_mode != 2'd0) begin
                    exp_q.push_back(res_t'({m_pend_d, m_pend_t, 1'b0}));
                    m_pend = 1'b0;
                end else if (in_ready) begin
                    if (FUSE && m_pend) begin
                        exp_q.push_back(res_t'({m_pend_d | {16'h0000, in_imm}, in_tag, 1'b1}));
                        m_pend = 1'b0;
                    end else if (FUSE && in_mode == 2'd2 && in_fuse) begin
                        m_pend   = 1'b1;
                        m_pend_d = model_ext(in_imm, in_mode);
                        m_pend_t = in_tag;
                    end else begin
                        exp_q.push_back(res_t'({model_ext(in_imm, in_mode), in_tag, 1'b0}));
                    end
                end
            end
        end
    end

    // Call at posedge+1; returns at posedge+1 after the accepting edge, valid still high.
    task automatic send(input logic [15:0] imm, input logic [1:0] mode, input logic fuse,
                        input logic [3:0] tag, output int waits);
        int c = 0;
        in_valid = 1'b1; in_imm = imm; in_mode = mode; in_fuse = fuse; in_tag = tag;
        @(negedge clk);
        while (!in_ready && c < 50) begin
            c++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: tag %0d in_ready stayed 0, required 1", tag);
        end else begin
            n_acc++;
        end
        waits = c;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_fuse  = 1'b0;
    endtask

    task automatic drain(input string name);
        int c = 0;
        while (exp_q.size() != 0 && c < 100) begin
            @(posedge clk);
            c++;
        end
        chk(name, exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] mode_exp [4];
        mode_exp[0] = 32'h00008001;
        mode_exp[1] = 32'hFFFF8001;
        mode_exp[2] = 32'h80010000;
        mode_exp[3] = 32'hFFFE0004;

        in_valid = 0; in_imm = 0; in_mode = 0; in_fuse = 0; in_tag = 0; out_ready = 1;
        repeat (2) @(posedge clk); #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_out_fused", out_fused, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", in_ready, 1);

        // Each mode, result visible one cycle after accept.
        for (int m = 0; m < 4; m++) begin
            send(16'h8001, 2'(m), 1'b0, 4'(m + 1), w);
            idle();
            @(negedge clk);
            chk("mode_valid", out_valid, 1);
            chk("mode_data", out_data, mode_exp[m]);
            chk("mode_tag", out_tag, m + 1);
            @(posedge clk); #1;
        end

        // Full throughput with out_ready high.
        for (int i = 0; i < 6; i++) begin
            send(16'(16'h7FF0 + i * 16'h1111), 2'(i), 1'b0, 4'(i + 8), w);
            chk("throughput_wait", w, 0);
        end
        idle();
        drain("tp_drain");

        // Backpressure: two accepts then in_ready low until release.
        log_q.delete();
        out_ready = 1'b0;
        n_acc = 0;
        fork
            begin
                for (int t = 1; t <= 5; t++)
                    send(16'(t * 16'h0103), 2'(t % 4), 1'b0, 4'(t), w);
                idle();
            end
            begin
                repeat (4) @(negedge clk);
                chk("bp_accepts", n_acc, 2);
                chk("bp_in_ready", in_ready, 0);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain("bp_drain");
        chk("bp_count", log_q.size(), 5);
        if (log_q.size() == 5)
            for (int i = 0; i < 5; i++) chk("bp_order", log_q[i].t, i + 1);

        // Reset with both registers full.
        log_q.delete();
        out_ready = 1'b0;
        send(16'hAAAA, 2'd0, 1'b0, 4'hA, w);
        send(16'hBBBB, 2'd1, 1'b0, 4'hB, w);
        idle();
        @(negedge clk);
        chk("rm_full_ready", in_ready, 0);
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        chk("rm_out_valid", out_valid, 0);
        chk("rm_in_ready", in_ready, 0);
        chk("rm_out_data", out_data, 0);
        chk("rm_out_tag", out_tag, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rm_ready_before_edge", in_ready, 0);
        @(posedge clk); #1;
        chk("rm_ready_after", in_ready, 1);
        chk("rm_valid_after", out_valid, 0);
        send(16'h0005, 2'd0, 1'b0, 4'h7, w);
        idle();
        drain("rm_drain");
        chk("rm_count", log_q.size(), 1);
        if (log_q.size() == 1) chk("rm_tag", log_q[0].t, 7);

        // Fusion pair.
        log_q.delete();
        send(16'h1234, 2'd2, 1'b1, 4'h2, w);
        idle();
        @(negedge clk);
        chk("fuse_first_valid", out_valid, !FUSE);
        @(posedge clk); #1;
        send(16'h5678, 2'd0, 1'b0, 4'h3, w);
        idle();
        drain("fuse_drain");
`ifdef IMM_EXT_FUSE_EN
        chk("fuse_count", log_q.size(), 1);
        if (log_q.size() == 1) begin
            chk("fuse_data", log_q[0].d, 32'h12345678);
            chk("fuse_tag", log_q[0].t, 3);
            chk("fuse_flag", log_q[0].f, 1);
        end
`else
        chk("fuse_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("nofuse_data0", log_q[0].d, 32'h12340000);
            chk("nofuse_tag0", log_q[0].t, 2);
            chk("nofuse_data1", log_q[1].d, 32'h00005678);
            chk("nofuse_flag1", log_q[1].f, 0);
        end
`endif

        // Fusion broken by a non-ZERO op.
        log_q.delete();
        send(16'h1234, 2'd2, 1'b1, 4'h4, w);
        send(16'hFFFF, 2'd1, 1'b0, 4'h5, w);
        idle();
        drain("break_drain");
        chk("break_ready_low_cycles", w, FUSE ? 1 : 0);
        chk("break_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("break_data0", log_q[0].d, 32'h12340000);
            chk("break_tag0", log_q[0].t, 4);
            chk("break_flag0", log_q[0].f, 0);
            chk("break_data1", log_q[1].d, 32'hFFFFFFFF);
            chk("break_tag1", log_q[1].t, 5);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, pipelined immediate extender for the single-cycle-to-pipelined datapath migration. Takes an IMM_W-bit instruction immediate plus a mode, produces a DATA_W-bit operand (zero-, sign-, upper-placed or branch-offset form). Output goes through a registered valid/ready stage with a one-entry skid buffer. It sits between decode and the ALU operand mux. An optional LUI/ORI fusion path assembles a full constant from two consecutive immediates.

## Interface
- IMM_W, 16, immediate width; must be at least 2.
- DATA_W, 32, result width; must be at least IMM_W+2.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  immediate offered.
- in_ready  out  1  block can accept; transfer when in_valid && in_ready.
- in_imm  in  IMM_W  raw immediate.
- in_mode  in  2  0 ZERO, 1 SIGN, 2 UPPER, 3 BRANCH.
- in_fuse  in  1  UPPER op requests fusion with next op (fusion build only).
- in_tag  in  4  opaque sideband, returned with result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready.
- out_data  out  DATA_W  extended result.
- out_tag  out  4  tag of the op that completed the result.
- out_fused  out  1  result is a fused UPPER|ZERO pair.

## Operation
- ZERO: {zeros, imm}. SIGN: imm[IMM_W-1] replicated to DATA_W. UPPER: imm at [DATA_W-1 : DATA_W-IMM_W], zeros below. BRANCH: sign-extend, then shift left 2, truncate to DATA_W; bits [1:0] = 0.
- Output stage holds a main register (out_*) and a skid register.
- Accepted op goes to main if main is empty or draining this cycle, else to skid.
- in_ready = !skid_valid (registered).
- Main draining with skid full: skid moves to main; in_ready rises the next cycle.
- Ordering is strictly FIFO. No op is dropped or duplicated.
- Reset, asserted at any time, including mid-stream or mid-fusion:
  - out_valid, skid_valid, out_fused = 0; out_data = 0; out_tag = 0.
  - in_ready = 0.
  - FSM goes to IDLE.
  - In-flight ops are discarded.
- in_ready = 1 on the first clk edge after rst falls.

## Timing
- Latency: accept at edge N, out_valid at edge N+1 if the output stage was free.
- Throughput: 1 op/cycle with out_ready held high.
- out_ready low for k cycles: accepts at most 2 ops, then in_ready = 0 until the stall clears.
- out_data and out_tag are stable while out_valid && !out_ready.
- Simultaneous accept and drain with skid empty: the new op replaces main; no bubble.

## Configuration
- Macro: IMM_EXT_FUSE_EN.
- Defined: adds FSM states IDLE and HOLD, plus a pending register (data, tag).
  - IDLE, accepted UPPER with in_fuse = 1: latch into pending, produce no output, go to HOLD.
  - HOLD, accepted ZERO: emit pending | zero-extended imm, with the ZERO op's tag and out_fused = 1; go to IDLE.
  - HOLD, in_valid with mode != ZERO: in_ready = 0 that cycle. Pending is emitted unfused (out_fused = 0) when the output stage has room; go to IDLE. The op is accepted the next cycle.
  - HOLD, no input: wait indefinitely.
- Undefined:
  - in_fuse is ignored; there is no HOLD state and no pending register.
  - out_fused is tied to 0.

## Structure
- Package imm_ext_pkg holds:
  - mode enum (IMM_ZERO, IMM_SIGN, IMM_UPPER, IMM_BRANCH);
  - fusion FSM state enum;
  - TAG_W = 4;
  - a pure function imm_extend(imm, mode) parametrised by widths.
- One sub-module, imm_skid_stage: the generic main-plus-skid valid/ready register, payload width parametrised. imm_extend_pipe instantiates it once with payload {data, tag, fused}.

## Test plan
- Modes, IMM_W=16, DATA_W=32, imm = 0x8001, out_ready = 1:
  - ZERO -> 0x00008001.
  - SIGN -> 0xFFFF8001.
  - UPPER -> 0x80010000.
  - BRANCH -> 0xFFFE0004.
  - Each arrives one cycle after accept.
- Backpressure: 5 back-to-back ops tags 1..5 with out_ready = 0 for 4 cycles -> in_ready drops after 2 accepts; after release, tags emerge 1..5 in order with no loss.
- Reset mid-stream: both registers full, rst pulsed for 1 cycle -> out_valid = 0 and in_ready = 0 during rst; in_ready = 1 next edge; stale tags never appear.
- Fusion, macro defined:
  - UPPER 0x1234 fuse, tag 2, then ZERO 0x5678, tag 3 -> one result 0x12345678, tag 3, out_fused = 1.
- Fusion break, macro defined:
  - UPPER 0x1234 fuse, then SIGN 0xFFFF -> 0x12340000 (out_fused = 0), then 0xFFFFFFFF.
  - in_ready is low for exactly one cycle.
- Macro undefined: same fusion stimulus -> two separate results 0x12340000 and 0x00005678; out_fused always 0.
